ula_74181: RTL and testbench
============================

Name: ula_74181

Overview:
4-bit ALU modelled on the 74181 function set, used as the adder slice of the shift-add multiplier datapath.
- Combinational result path: f, cout, a_eq_b settle in the same cycle as the inputs.
- Registered copy of the result (f_q, cout_q) for pipelined consumers.
- Arithmetic mode selects one of 16 functions via s; logic mode is fixed XOR.

Parameters:
none (width fixed at 4 bits)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
a  input  4  operand A
b  input  4  operand B
s  input  4  function select
m  input  1  mode: 0 = arithmetic, 1 = logic
cin  input  1  carry in, active-high (1 adds +1 in arithmetic mode)
f  output  4  combinational result
cout  output  1  combinational carry out
a_eq_b  output  1  combinational; 1 when f == 4'b1111
f_q  output  4  f registered on clk
cout_q  output  1  cout registered on clk

Behaviour:
- Arithmetic mode (m=0):
  - Result is the 5-bit sum X + Y + cin, with X and Y zero-extended 4-bit operands.
  - f = sum[3:0]; cout = sum[4].
  - All data and carries are active-high.
- Operand pairs (X, Y) per s:
  - 0000: A, 0
  - 0001: A|B, 0
  - 0010: A|~B, 0
  - 0011: 0, 1111
  - 0100: A, A&~B
  - 0101: A|B, A&~B
  - 0110: A, ~B (A minus B minus 1)
  - 0111: A&~B, 1111
  - 1000: A, A&B
  - 1001: A, B (A plus B)
  - 1010: A|~B, A&B
  - 1011: A&B, 1111
  - 1100: A, A
  - 1101: A|B, A
  - 1110: A|~B, A
  - 1111: A, 1111 (A minus 1)
- Logic mode (m=1):
  - f = a ^ b for every value of s.
  - cout = 0; cin is ignored.
- a_eq_b = &f in both modes.
- f, cout and a_eq_b are purely combinational, with no dependence on clk or rst. They must be valid within one delta after any input change.
- Registered path:
  - On each rising clk, f_q <= f and cout_q <= cout, giving one cycle latency.
  - No enable; updates every cycle.
- Reset: when rst=1 at a rising edge, f_q <= 4'b0000 and cout_q <= 0. Reset has priority over the data capture. Combinational outputs are unaffected by reset.
- Overflow / wrap:
  - Sums wrap modulo 16 in f, with the carry reported on cout.
  - Maximum case: 15+15+1 gives f=15, cout=1.
- No X propagation from unused paths: in logic mode the arithmetic adder result must not reach f or cout.

Test Plan:
- m=0, s=1001, combinational sums: (0,0,0)->f=0,cout=0; (5,3,0)->f=8,cout=0; (15,1,0)->f=0,cout=1; (8,8,0)->f=0,cout=1; (7,8,1)->f=0,cout=1; (15,15,1)->f=15,cout=1,a_eq_b=1.
- m=1, s=1001, cin=0: (0,0)->f=0; (15,15)->f=0; (5,3)->f=6; (12,10)->f=6; (15,0)->f=15,a_eq_b=1. cout=0 in all cases. Repeat a=5,b=3 with s=0000 and cin=1 -> f=6, cout=0.
- m=0, other selects: s=0110 a=5 b=3 cin=1 -> f=2,cout=1; s=0110 a=3 b=5 cin=1 -> f=14,cout=0; s=1111 a=0 cin=0 -> f=15,cout=0; s=1100 a=9 cin=0 -> f=2,cout=1; s=0011 cin=1 -> f=0,cout=1.
- Registered path: a=5,b=3,m=0,s=1001 -> f_q=8,cout_q=0 after the next rising edge. Then a=15,b=1 -> f_q=0,cout_q=1 one edge later; f_q holds its old value until that edge.
- Reset: rst=1 at an edge with a=15,b=15,cin=1 -> f_q=0,cout_q=0 while combinational f=15,cout=1. Release rst -> f_q=15,cout_q=1 on the next edge.
- Sweep: all 16 s × exhaustive a,b,cin in m=0 against a behavioural model of the operand table. All a,b in m=1 -> f==a^b, cout==0.

Source files
------------

// File: rtl/ula_74181.sv
// 4-bit ALU slice modelled on the 74181 function set.
// Arithmetic mode adds an operand pair chosen by s, plus cin.
// Logic mode is a fixed XOR. The combinational result is also
// captured into f_q/cout_q for pipelined consumers.
module ula_74181 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout,
  output logic       a_eq_b,
  output logic [3:0] f_q,
  output logic       cout_q
);

  logic [3:0] x_op;
  logic [3:0] y_op;
  logic [4:0] sum;

  // Select the adder operand pair for the current function code.
  always_comb begin
    x_op = 4'b0000;
    y_op = 4'b0000;
    case (s)
      4'b0000: begin x_op = a;       y_op = 4'b0000; end
      4'b0001: begin x_op = a | b;   y_op = 4'b0000; end
      4'b0010: begin x_op = a | ~b;  y_op = 4'b0000; end
      4'b0011: begin x_op = 4'b0000; y_op = 4'b1111; end
      4'b0100: begin x_op = a;       y_op = a & ~b;  end
      4'b0101: begin x_op = a | b;   y_op = a & ~b;  end
      4'b0110: begin x_op = a;       y_op = ~b;      end
      4'b0111: begin x_op = a & ~b;  y_op = 4'b1111; end
      4'b1000: begin x_op = a;       y_op = a & b;   end
      4'b1001: begin x_op = a;       y_op = b;       end
      4'b1010: begin x_op = a | ~b;  y_op = a & b;   end
      4'b1011: begin x_op = a & b;   y_op = 4'b1111; end
      4'b1100: begin x_op = a;       y_op = a;       end
      4'b1101: begin x_op = a | b;   y_op = a;       end
      4'b1110: begin x_op = a | ~b;  y_op = a;       end
      default: begin x_op = a;       y_op = 4'b1111; end
    endcase
  end

  // Add the pair with carry-in, then pick the adder or the XOR by mode;
  // the mode mux keeps the adder result off f/cout in logic mode.
  always_comb begin
    sum = {1'b0, x_op} + {1'b0, y_op} + {4'b0000, cin};
    if (m) begin
      f    = a ^ b;
      cout = 1'b0;
    end else begin
      f    = sum[3:0];
      cout = sum[4];
    end
    a_eq_b = &f;
  end

  // Capture the result every cycle; reset clears the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q    <= 4'b0000;
      cout_q <= 1'b0;
    end else begin
      f_q    <= f;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_ula_74181.sv
// Self-checking bench for ula_74181: directed vectors, exhaustive sweep
// against an integer reference model, and randomized registered-path runs.
module tb_ula_74181;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, s;
  logic       m, cin;
  logic [3:0] f, f_q;
  logic       cout, a_eq_b, cout_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       cin;
    logic [3:0] ef;
    logic       ec;
  } vec_t;

  ula_74181 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .f(f), .cout(cout), .a_eq_b(a_eq_b), .f_q(f_q), .cout_q(cout_q)
  );

  always #5 clk = ~clk;

  // Reference: operand values as plain integers, result = X + Y + cin.
  function automatic logic [4:0] ref_alu(input int ai, input int bi,
                                         input int si, input int mi,
                                         input int ci);
    int nb, x, y, total;
    nb = 15 - bi;
    x = 0;
    y = 0;
    if (mi != 0) return {1'b0, 4'(ai ^ bi)};
    case (si)
      0:  begin x = ai;        y = 0;         end
      1:  begin x = ai | bi;   y = 0;         end
      2:  begin x = ai | nb;   y = 0;         end
      3:  begin x = 0;         y = 15;        end
      4:  begin x = ai;        y = ai & nb;   end
      5:  begin x = ai | bi;   y = ai & nb;   end
      6:  begin x = ai;        y = nb;        end
      7:  begin x = ai & nb;   y = 15;        end
      8:  begin x = ai;        y = ai & bi;   end
      9:  begin x = ai;        y = bi;        end
      10: begin x = ai | nb;   y = ai & bi;   end
      11: begin x = ai & bi;   y = 15;        end
      12: begin x = ai;        y = ai;        end
      13: begin x = ai | bi;   y = ai;        end
      14: begin x = ai | nb;   y = ai;        end
      default: begin x = ai;   y = 15;        end
    endcase
    total = x + y + ci;
    return {(total >= 16) ? 1'b1 : 1'b0, 4'(total % 16)};
  endfunction

  task automatic apply(input logic [3:0] ai, input logic [3:0] bi,
                       input logic [3:0] si, input logic mi, input logic ci);
    a = ai; b = bi; s = si; m = mi; cin = ci;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(4'd15, 4'd15, 4'b1001, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (f_q !== 4'd0 || cout_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_reg: f_q=%0d cout_q=%0d expected 0 0", f_q, cout_q);
    end
    checks++;
    if (f !== 4'd15 || cout !== 1'b1 || a_eq_b !== 1'b1) begin
      failures++;
      $display("FAIL reset_comb: f=%0d cout=%0d eq=%0d expected 15 1 1", f, cout, a_eq_b);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (f_q !== 4'd15 || cout_q !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: f_q=%0d cout_q=%0d expected 15 1", f_q, cout_q);
    end
  endtask

  task automatic test_add();
    vec_t v[$];
    v.push_back('{4'd0,  4'd0,  4'b1001, 1'b0, 1'b0, 4'd0,  1'b0});
    v.push_back('{4'd5,  4'd3,  4'b1001, 1'b0, 1'b0, 4'd8,  1'b0});
    v.push_back('{4'd15, 4'd1,  4'b1001, 1'b0, 1'b0, 4'd0,  1'b1});
    v.push_back('{4'd8,  4'd8,  4'b1001, 1'b0, 1'b0, 4'd0,  1'b1});
    v.push_back('{4'd7,  4'd8,  4'b1001, 1'b0, 1'b1, 4'd0,  1'b1});
    v.push_back('{4'd15, 4'd15, 4'b1001, 1'b0, 1'b1, 4'd15, 1'b1});
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].s, v[i].m, v[i].cin);
      #1;
      checks++;
      if (f !== v[i].ef || cout !== v[i].ec || a_eq_b !== (&v[i].ef)) begin
        failures++;
        $display("FAIL add[%0d]: f=%0d cout=%0d eq=%0d expected %0d %0d %0d",
                 i, f, cout, a_eq_b, v[i].ef, v[i].ec, &v[i].ef);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[$];
    v.push_back('{4'd0,  4'd0,  4'b1001, 1'b1, 1'b0, 4'd0,  1'b0});
    v.push_back('{4'd15, 4'd15, 4'b1001, 1'b1, 1'b0, 4'd0,  1'b0});
    v.push_back('{4'd5,  4'd3,  4'b1001, 1'b1, 1'b0, 4'd6,  1'b0});
    v.push_back('{4'd12, 4'd10, 4'b1001, 1'b1, 1'b0, 4'd6,  1'b0});
    v.push_back('{4'd15, 4'd0,  4'b1001, 1'b1, 1'b0, 4'd15, 1'b0});
    v.push_back('{4'd5,  4'd3,  4'b0000, 1'b1, 1'b1, 4'd6,  1'b0});
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].s, v[i].m, v[i].cin);
      #1;
      checks++;
      if (f !== v[i].ef || cout !== v[i].ec || a_eq_b !== (&v[i].ef)) begin
        failures++;
        $display("FAIL logic[%0d]: f=%0d cout=%0d eq=%0d expected %0d %0d %0d",
                 i, f, cout, a_eq_b, v[i].ef, v[i].ec, &v[i].ef);
      end
    end
  endtask

  task automatic test_other_sel();
    vec_t v[$];
    v.push_back('{4'd5, 4'd3, 4'b0110, 1'b0, 1'b1, 4'd2,  1'b1});
    v.push_back('{4'd3, 4'd5, 4'b0110, 1'b0, 1'b1, 4'd14, 1'b0});
    v.push_back('{4'd0, 4'd6, 4'b1111, 1'b0, 1'b0, 4'd15, 1'b0});
    v.push_back('{4'd9, 4'd4, 4'b1100, 1'b0, 1'b0, 4'd2,  1'b1});
    v.push_back('{4'd7, 4'd2, 4'b0011, 1'b0, 1'b1, 4'd0,  1'b1});
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].s, v[i].m, v[i].cin);
      #1;
      checks++;
      if (f !== v[i].ef || cout !== v[i].ec || a_eq_b !== (&v[i].ef)) begin
        failures++;
        $display("FAIL sel[%0d]: f=%0d cout=%0d eq=%0d expected %0d %0d %0d",
                 i, f, cout, a_eq_b, v[i].ef, v[i].ec, &v[i].ef);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    apply(4'd5, 4'd3, 4'b1001, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (f_q !== 4'd8 || cout_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_first: f_q=%0d cout_q=%0d expected 8 0", f_q, cout_q);
    end
    @(negedge clk);
    apply(4'd15, 4'd1, 4'b1001, 1'b0, 1'b0);
    #1;
    checks++;
    if (f_q !== 4'd8 || cout_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_hold: f_q=%0d cout_q=%0d expected 8 0", f_q, cout_q);
    end
    @(posedge clk); #1;
    checks++;
    if (f_q !== 4'd0 || cout_q !== 1'b1) begin
      failures++;
      $display("FAIL reg_second: f_q=%0d cout_q=%0d expected 0 1", f_q, cout_q);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] exp;
    int bad = 0;
    for (int mi = 0; mi < 2; mi++)
      for (int si = 0; si < 16; si++)
        for (int ai = 0; ai < 16; ai++)
          for (int bi = 0; bi < 16; bi++)
            for (int ci = 0; ci < 2; ci++) begin
              if (mi == 1 && si != 0) continue;
              apply(4'(ai), 4'(bi), 4'(si), 1'(mi), 1'(ci));
              #1;
              exp = ref_alu(ai, bi, si, mi, ci);
              checks++;
              if (f !== exp[3:0] || cout !== exp[4] || a_eq_b !== (&exp[3:0])) begin
                failures++;
                if (bad < 10)
                  $display("FAIL sweep m=%0d s=%0d a=%0d b=%0d cin=%0d: f=%0d cout=%0d eq=%0d expected %0d %0d %0d",
                           mi, si, ai, bi, ci, f, cout, a_eq_b, exp[3:0], exp[4], &exp[3:0]);
                bad++;
              end
            end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_q;
    logic [4:0] exp_c;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 15) == 0);
      apply(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      exp_c = ref_alu(int'(a), int'(b), int'(s), int'(m), int'(cin));
      exp_q = rst ? 5'd0 : exp_c;
      #1;
      checks++;
      if (f !== exp_c[3:0] || cout !== exp_c[4]) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand_comb[%0d]: f=%0d cout=%0d expected %0d %0d",
                   n, f, cout, exp_c[3:0], exp_c[4]);
        bad++;
      end
      @(posedge clk); #1;
      checks++;
      if (f_q !== exp_q[3:0] || cout_q !== exp_q[4]) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand_reg[%0d]: f_q=%0d cout_q=%0d expected %0d %0d",
                   n, f_q, cout_q, exp_q[3:0], exp_q[4]);
        bad++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apply(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_logic();
    test_other_sel();
    test_registered();
    test_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
